// File: rtl/cache_if.sv
// Bus between the memory controller and the data cache: lookup, store and
// line-install requests in; the registered lookup result out.
interface cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  we;
    logic [31:0]           wdata;
    logic                  bwe;
    logic [LINE_WIDTH-1:0] bdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic                  hit;
    logic [1:0]            bindex;

    modport master (
        output raddr, waddr, we, wdata, bwe, bdata,
        input  rdata, hit, bindex
    );

    modport slave (
        input  raddr, waddr, we, wdata, bwe, bdata,
        output rdata, hit, bindex
    );
endinterface

// File: rtl/cache.sv
// Direct-mapped, write-through, no-write-allocate data cache. Lookups have one
// cycle of latency; stores only update resident lines; installs replace a line.
module cache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int INDEX_WIDTH = 6
) (
    input logic   i_clk,
    input logic   i_rst_n,
    cache_if.slave bus
);
    localparam int NUM_LINES = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 4;

    logic [LINE_WIDTH-1:0] data_ram [NUM_LINES];
    logic [TAG_WIDTH-1:0]  tag_ram  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid;
    logic [ADDR_WIDTH-1:0] raddr_q;

    logic [INDEX_WIDTH-1:0] ridx;
    logic [TAG_WIDTH-1:0]   rtag;
    logic                   rhit;
    logic [INDEX_WIDTH-1:0] widx;
    logic [TAG_WIDTH-1:0]   wtag;
    logic [1:0]             wword;
    logic                   whit;
    logic                   unused_ok;

    assign ridx  = raddr_q[INDEX_WIDTH+3:4];
    assign rtag  = raddr_q[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign rhit  = valid[ridx] && (tag_ram[ridx] == rtag);

    assign widx  = bus.waddr[INDEX_WIDTH+3:4];
    assign wtag  = bus.waddr[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign wword = bus.waddr[3:2];
    assign whit  = valid[widx] && (tag_ram[widx] == wtag);

    // Byte-offset bits within a word carry no meaning for this cache.
    assign unused_ok = ^{raddr_q[1:0], bus.waddr[1:0]};

    // Data and tag arrays deliberately have no reset; only valid bits clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid   <= '0;
            raddr_q <= '0;
        end else begin
            raddr_q <= bus.raddr;
            if (bus.bwe) begin
                data_ram[widx] <= bus.bdata;
                tag_ram[widx]  <= wtag;
                valid[widx]    <= 1'b1;
            end else if (bus.we && whit) begin
                data_ram[widx][{wword, 5'b0} +: 32] <= bus.wdata;
            end
        end
    end

    assign bus.hit    = rhit;
    assign bus.rdata  = rhit ? data_ram[ridx] : '0;
    assign bus.bindex = raddr_q[3:2];
endmodule

// File: tb/tb_cache.sv
// Directed bench for the data cache: stimulus pushes expected lookup results
// into a queue and a negedge monitor pops and compares them one cycle later.
module tb_cache;
    logic clk;
    logic rst_n;
    logic lookup_req;
    logic pend;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         hit;
        logic [1:0]   bindex;
        logic [127:0] line;
        logic [31:0]  addr;
    } exp_t;

    exp_t exp_q[$];

    cache_if bus ();

    cache dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L5 = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] L0 = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;
    localparam logic [127:0] L7 = 128'h7A7A7A7A_7B7B7B7B_7C7C7C7C_7D7D7D7D;
    localparam logic [127:0] L3 = 128'h33330000_33331111_33332222_33333333;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) pend <= lookup_req;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: result presented with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("hit@%h", e.addr), {127'b0, bus.hit}, {127'b0, e.hit});
                check($sformatf("bindex@%h", e.addr), {126'b0, bus.bindex}, {126'b0, e.bindex});
                check($sformatf("data@%h", e.addr), bus.rdata, e.line);
            end
        end
    end

    task automatic drive(input logic [31:0] ra, input logic look,
                         input logic we, input logic bwe,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [127:0] bd,
                         input logic exp_hit, input logic [127:0] exp_line);
        exp_t e;
        bus.raddr  = ra;
        bus.we     = we;
        bus.bwe    = bwe;
        bus.waddr  = wa;
        bus.wdata  = wd;
        bus.bdata  = bd;
        lookup_req = look;
        if (look) begin
            e.hit    = exp_hit;
            e.bindex = ra[3:2];
            e.line   = exp_hit ? exp_line : 128'h0;
            e.addr   = ra;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a, input logic h, input logic [127:0] line);
        drive(a, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, h, line);
    endtask

    task automatic install(input logic [31:0] a, input logic [127:0] line);
        drive(32'h0, 1'b0, 1'b0, 1'b1, a, 32'h0, line, 1'b0, 128'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drive(32'h0, 1'b0, 1'b1, 1'b0, a, d, 128'h0, 1'b0, 128'h0);
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 1'b0, 128'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        lookup_req = 1'b0;
        pend       = 1'b0;
        bus.raddr  = 32'h104;
        bus.waddr  = 32'h0;
        bus.we     = 1'b0;
        bus.wdata  = 32'h0;
        bus.bwe    = 1'b0;
        bus.bdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit", {127'b0, bus.hit}, 128'h0);
        check("rst_data", bus.rdata, 128'h0);
        check("rst_bindex", {126'b0, bus.bindex}, 128'h0);
        rst_n = 1'b1;

        lookup(32'h100, 1'b0, 128'h0);
        install(32'h100, L1);
        lookup(32'h104, 1'b1, L1);
        lookup(32'h10C, 1'b1, L1);
        lookup(32'h103, 1'b1, L1);

        install(32'h500, L5);
        lookup(32'h100, 1'b0, 128'h0);
        lookup(32'h50C, 1'b1, L5);

        install(32'h100, L1);
        store(32'h108, 32'hDEADBEEF);
        lookup(32'h108, 1'b1, 128'h44444444_DEADBEEF_22222222_11111111);
        // Store and lookup of the same line in one cycle: lookup sees the store.
        drive(32'h100, 1'b1, 1'b1, 1'b0, 32'h102, 32'hCAFEF00D, 128'h0,
              1'b1, 128'h44444444_DEADBEEF_22222222_CAFEF00D);
        idle();

        install(32'h000, L0);
        store(32'h2000, 32'h12345678);
        store(32'h3F0, 32'h9ABCDEF0);
        lookup(32'h2000, 1'b0, 128'h0);
        lookup(32'h000, 1'b1, L0);
        lookup(32'h00C, 1'b1, L0);
        lookup(32'h3F0, 1'b0, 128'h0);

        drive(32'h100, 1'b1, 1'b1, 1'b1, 32'h104, 32'hFFFFFFFF, L7, 1'b1, L7);
        lookup(32'h104, 1'b1, L7);
        idle();
        idle();

        // Reset lands while an install is being presented; the install is lost.
        bus.bwe   = 1'b1;
        bus.waddr = 32'h300;
        bus.bdata = L3;
        bus.raddr = 32'h10C;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_hit", {127'b0, bus.hit}, 128'h0);
        check("midrst_bindex", {126'b0, bus.bindex}, 128'h0);
        rst_n = 1'b1;
        idle();
        lookup(32'h100, 1'b0, 128'h0);
        lookup(32'h000, 1'b0, 128'h0);
        lookup(32'h300, 1'b0, 128'h0);
        install(32'h300, L3);
        lookup(32'h308, 1'b1, L3);
        idle();
        idle();

        check("queue_drained", 128'(exp_q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
